// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: field widths, the MM/WB bundle
// and the stage-register occupancy state encoding.
package riscv_pipe_pkg;

    localparam int unsigned ALU_W    = 32;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned RADDR_W  = 5;
    localparam int unsigned DCNTRL_W = 2;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FLAGS_W  = 3;
    localparam int unsigned MMWB_W   = 113;

    typedef struct packed {
        logic [ALU_W-1:0]    alu_result;
        logic [PC_W-1:0]     pc;
        logic [RADDR_W-1:0]  r3_addr;
        logic                mem_rw;
        logic [DCNTRL_W-1:0] r3_dcntrl;
        logic [OPCODE_W-1:0] opcode;
        logic [FLAGS_W-1:0]  flags;
        logic [ALU_W-1:0]    data_out;
    } mm_wb_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake control for pipe_stage_reg: state, in_ready/out_valid
// and datapath load enables. Two-entry skid mode under PIPE_SKID_EN.
module pipe_skid_ctrl
    import riscv_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ld_main,
`ifdef PIPE_SKID_EN
    output logic       ld_skid,
    output logic       main_sel_skid,
`endif
    output logic [1:0] occupancy
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       vld_q;
    logic       push;
    logic       pop;
`ifdef PIPE_SKID_EN
    logic       rdy_q;
`endif

`ifdef PIPE_SKID_EN
    assign in_ready = rdy_q;
`else
    assign in_ready = reset & (~vld_q | out_ready);
`endif

    assign out_valid = vld_q;
    assign occupancy = state_q;
    assign push      = in_valid & in_ready;
    assign pop       = vld_q & out_ready;

    // State plus flopped copies of out_valid and in_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            vld_q   <= 1'b0;
`ifdef PIPE_SKID_EN
            rdy_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            vld_q   <= (state_d != ST_EMPTY);
`ifdef PIPE_SKID_EN
            rdy_q   <= (state_d != ST_TWO);
`endif
        end
    end

    // Next state and load enables; flush wins over any transfer
    always_comb begin
        state_d       = state_q;
        ld_main       = 1'b0;
`ifdef PIPE_SKID_EN
        ld_skid       = 1'b0;
        main_sel_skid = 1'b0;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (1'b1)
                (state_q == ST_EMPTY): begin
                    if (push) begin
                        state_d = ST_ONE;
                        ld_main = 1'b1;
                    end
                end
                (state_q == ST_ONE): begin
`ifdef PIPE_SKID_EN
                    if (push && !pop) begin
                        state_d = ST_TWO;
                        ld_skid = 1'b1;
                    end else if (pop && !push) begin
                        state_d = ST_EMPTY;
                    end else if (push && pop) begin
                        ld_main = 1'b1;
                    end
`else
                    if (push) begin
                        ld_main = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
`endif
                end
`ifdef PIPE_SKID_EN
                (state_q == ST_TWO): begin
                    if (pop) begin
                        state_d       = ST_ONE;
                        ld_main       = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Payload-agnostic pipeline stage register with valid/ready and flush.
// Define PIPE_SKID_EN for the two-entry skid version with registered in_ready.
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W = MMWB_W,
    parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);

    logic                 ld_main;
    logic [PAYLOAD_W-1:0] main_q;
`ifdef PIPE_SKID_EN
    logic                 ld_skid;
    logic                 main_sel_skid;
    logic [PAYLOAD_W-1:0] skid_q;
`endif

    pipe_skid_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ld_main       (ld_main),
`ifdef PIPE_SKID_EN
        .ld_skid       (ld_skid),
        .main_sel_skid (main_sel_skid),
`endif
        .occupancy     (occupancy)
    );

    assign out_data = main_q;

`ifdef PIPE_SKID_EN
    // Main register takes a new push or the promoted skid entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= RESET_VAL;
        end else if (ld_main) begin
            main_q <= main_sel_skid ? skid_q : in_data;
        end
    end

    // Skid register absorbs the push that arrives while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_q <= RESET_VAL;
        end else if (ld_skid) begin
            skid_q <= in_data;
        end
    end
`else
    // Single entry: main register loads on every accepted push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= RESET_VAL;
        end else if (ld_main) begin
            main_q <= in_data;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table stream, corner
// sequences and a randomized run against a FIFO scoreboard.
module tb_pipe_stage_reg;

    localparam int unsigned W  = 16;
    localparam logic [W-1:0] RV = 16'h5A3C;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         ev;
        logic [W-1:0] ed;
        logic [1:0]   eocc;
    } vec_t;

    vec_t tbl[9];

    pipe_stage_reg #(
        .PAYLOAD_W (W),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock: drive, check against the model, advance the model
    task automatic cycle(input logic fl, input logic iv,
                         input logic [W-1:0] id, input logic ordy,
                         output logic acc);
        logic exp_ir;
        logic pop;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        exp_ir = SKID ? (sb.size() < 2) : (sb.size() == 0 || ordy);
        chk("in_ready", W'(in_ready), W'(exp_ir));
        chk("out_valid", W'(out_valid), W'(sb.size() != 0));
        chk("occupancy", W'(occupancy), W'(sb.size()));
        if (sb.size() != 0) chk("out_data", out_data, sb[0]);
        acc = iv && exp_ir;
        pop = (sb.size() != 0) && ordy;
        @(posedge clk);
        if (pop) void'(sb.pop_front());
        if (fl) sb.delete();
        else if (acc) sb.push_back(id);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            cycle(1'b0, 1'b0, '0, 1'b1, acc);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    initial begin
        logic         acc;
        logic         have;
        logic         fl;
        logic [W-1:0] offer;
        logic [W-1:0] pend[$];

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, W'(i + 1), 1'b1, 1'b1, W'(i + 1), 2'd1};
        tbl[8] = '{1'b0, W'(0), 1'b1, 1'b0, W'(8), 2'd0};

        // reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_occupancy", W'(occupancy), W'(0));
        chk("rst_out_data", out_data, RV);
        chk("rst_in_ready", W'(in_ready), W'(SKID));
        reset = 1'b1;

        // streaming table
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy, acc);
            chk("tbl_out_valid", W'(out_valid), W'(tbl[i].ev));
            chk("tbl_out_data", out_data, tbl[i].ed);
            chk("tbl_occupancy", W'(occupancy), W'(tbl[i].eocc));
        end

        // back-pressure: 0xA,0xB,0xC offered with out_ready low
        pend.push_back(W'(16'hA));
        pend.push_back(W'(16'hB));
        pend.push_back(W'(16'hC));
        for (int k = 0; k < 20 && pend.size() != 0; k++) begin
            cycle(1'b0, 1'b1, pend[0], k >= 3, acc);
            if (acc) void'(pend.pop_front());
            if (k == 2) begin
                chk("bp_occupancy", W'(occupancy), W'(SKID ? 2 : 1));
                chk("bp_in_ready", W'(in_ready), W'(0));
            end
        end
        checks++;
        if (pend.size() != 0) begin
            errors++;
            $display("FAIL bp_accept: %0d left, expected 0", pend.size());
        end
        drain();

        // flush together with a push
        cycle(1'b0, 1'b1, W'(16'hE), 1'b0, acc);
        cycle(1'b0, 1'b1, W'(16'hF), 1'b0, acc);
        chk("fl_pre_occ", W'(occupancy), W'(SKID ? 2 : 1));
        cycle(1'b1, 1'b1, W'(16'hD), 1'b0, acc);
        chk("fl_out_valid", W'(out_valid), W'(0));
        chk("fl_occupancy", W'(occupancy), W'(0));
        chk("fl_keep_data", out_data, W'(16'hE));
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b1, acc);

        // async reset between edges while full
        cycle(1'b0, 1'b1, W'(16'h11), 1'b0, acc);
        cycle(1'b0, 1'b1, W'(16'h22), 1'b0, acc);
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", W'(out_valid), W'(0));
        chk("ar_out_data", out_data, RV);
        chk("ar_occupancy", W'(occupancy), W'(0));
        chk("ar_in_ready", W'(in_ready), W'(SKID));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // random valid/ready against the scoreboard
        have  = 1'b0;
        offer = '0;
        for (int n = 0; n < 10000; n++) begin
            if (!have) begin
                have  = ($urandom_range(0, 1) == 1);
                offer = W'($urandom);
            end
            fl = ($urandom_range(0, 63) == 0);
            cycle(fl, have, offer, $urandom_range(0, 1) == 1, acc);
            if (acc) have = 1'b0;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying an arbitrary packed payload between any two processor stages (IF/ID, ID/EX, EX/MM, MM/WB) with a valid/ready handshake, synchronous flush and occupancy reporting. It replaces fixed, enable-only stage registers. Upstream back-pressure is derived from downstream ready, so stalls propagate without external enable logic. An optional second entry (skid) keeps full throughput while the ready path stays registered.

## Interface
- PAYLOAD_W, default 113 — payload width in bits; 113 is the MM/WB bundle: alu_result 32, pc 32, R3_addr 5, mem_rw 1, R3_dcntrl 2, opcode 6, flags 3, data_out 32.
- RESET_VAL, default 0 (PAYLOAD_W bits) — payload register value after reset.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk upstream.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  PAYLOAD_W  payload to downstream.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- Transfer in: in_valid && in_ready at the rising edge. Transfer out: out_valid && out_ready at the rising edge.
- Order is strictly FIFO; no entry is dropped or duplicated except on flush.
- States, with PIPE_SKID_EN defined:
  - EMPTY (occ 0): push → ONE.
  - ONE (occ 1): push without pop → TWO; pop without push → EMPTY; push with pop → ONE, new data in the main register.
  - TWO (occ 2): pop → ONE, skid entry moves to the main register; a push is impossible because in_ready = 0.
- Flush has priority over every transfer: next state is EMPTY, and any same-cycle push is discarded. A same-cycle pop still counts as consumed downstream.
- Payload registers keep their last value on flush and when empty. Only the valid state is cleared.
- Upstream must hold in_data stable while in_valid && !in_ready. The block does not check this.
- Reset, asserted asynchronously at any time (including mid-transfer):
  - state becomes EMPTY; out_valid = 0; occupancy = 0.
  - out_data = RESET_VAL; the skid register = RESET_VAL.
  - in_ready = 1 with PIPE_SKID_EN, 0 without it.

## Timing
- Latency: a push at edge N makes out_valid = 1 with that data after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle in steady state when out_ready = 1.
- With PIPE_SKID_EN:
  - in_ready = (state != TWO), taken directly from a flop; there is no combinational path from out_ready.
  - out_ready low for k cycles → at most one extra entry is absorbed, and in_ready drops at the following edge.
- Without PIPE_SKID_EN:
  - in_ready = !out_valid || out_ready, a combinational path from out_ready to in_ready.
- In both modes, out_valid and out_data are driven directly from flops.

## Configuration
- PIPE_SKID_EN defined: two-entry skid stage; registered in_ready; occupancy reaches 2.
- PIPE_SKID_EN undefined: single-entry stage, states EMPTY/ONE only; occupancy never exceeds 1; skid register absent. This mode matches legacy stall behaviour at lower area.

## Structure
- Shared package riscv_pipe_pkg holds:
  - field widths: ALU_W = 32, PC_W = 32, RADDR_W = 5, DCNTRL_W = 2, OPCODE_W = 6, FLAGS_W = 3;
  - MMWB_W = 113 and the packed mm_wb_t bundle;
  - state encoding localparams ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2.
- Stage instances pack and unpack their bundle via the package type. The block itself is payload-agnostic.
- One sub-module is natural: pipe_skid_ctrl, containing the state register, in_ready/out_valid generation and load enables. The datapath registers stay in pipe_stage_reg.

## Test plan
- Reset then stream: reset low 3 cycles, then push 0x1..0x8 with out_ready = 1 → out_data is 0x1..0x8 on consecutive cycles, each one cycle after its push; occupancy stays ≤ 1.
- Back-pressure (skid build): push 0xA, 0xB, 0xC while out_ready = 0 → with PIPE_SKID_EN, occupancy = 2, in_ready = 0 after 0xB, 0xC is held upstream; on release, output is 0xA, 0xB, 0xC in order. Without it, in_ready = 0 after 0xA.
- Flush with push: occupancy 2, flush = 1 together with in_valid = 1 (0xD) → next cycle out_valid = 0, occupancy = 0; 0xD never appears.
- Async reset mid-operation: assert reset between edges while occupancy = 2 → out_valid = 0 and out_data = RESET_VAL immediately, before the next clk edge.
- Random valid/ready (10k cycles, 50% each) against a scoreboard queue → no loss, no duplication, order preserved; occupancy always equals the scoreboard depth.
